// File: rtl/tcdm_bus_buffer.sv
// tcdm_bus_buffer: TCDM request FIFO plus registered response stage with an outstanding-request limit
module tcdm_bus_buffer #(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned BeWidth        = DataWidth / 8,
    parameter int unsigned ReqDepth       = 2,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  mst_req_i,
    input  logic [AddrWidth-1:0]                  mst_add_i,
    input  logic                                  mst_wen_i,
    input  logic [DataWidth-1:0]                  mst_wdata_i,
    input  logic [BeWidth-1:0]                    mst_be_i,
    output logic                                  mst_gnt_o,
    output logic                                  mst_r_valid_o,
    output logic [DataWidth-1:0]                  mst_r_rdata_o,
    output logic                                  mst_r_opc_o,
    output logic                                  slv_req_o,
    output logic [AddrWidth-1:0]                  slv_add_o,
    output logic                                  slv_wen_o,
    output logic [DataWidth-1:0]                  slv_wdata_o,
    output logic [BeWidth-1:0]                    slv_be_o,
    input  logic                                  slv_gnt_i,
    input  logic                                  slv_r_valid_i,
    input  logic [DataWidth-1:0]                  slv_r_rdata_i,
    input  logic                                  slv_r_opc_i,
    output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
    output logic                                  err_o
);
    localparam int unsigned EntW = AddrWidth + 1 + DataWidth + BeWidth;
    localparam int unsigned PtrW = ReqDepth > 1 ? $clog2(ReqDepth) : 1;
    localparam int unsigned FcW  = $clog2(ReqDepth + 1);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(ReqDepth - 1);
    localparam logic [FcW-1:0]  FullCnt = FcW'(ReqDepth);
    localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);

    logic [EntW-1:0]      mem [ReqDepth];
    logic [PtrW-1:0]      wr_ptr, rd_ptr;
    logic [FcW-1:0]       fifo_cnt;
    logic [CntW-1:0]      out_cnt;
    logic                 push, pop, full, empty, spurious, accept;
    logic                 r_valid_q, r_opc_q, err_q;
    logic [DataWidth-1:0] r_rdata_q;

    assign full      = fifo_cnt == FullCnt;
    assign empty     = fifo_cnt == '0;
    assign mst_gnt_o = !rst_i && !full;
    assign push      = mst_req_i && mst_gnt_o;
    assign slv_req_o = !rst_i && !empty && out_cnt < MaxCnt;
    assign pop       = slv_req_o && slv_gnt_i;
    assign {slv_add_o, slv_wen_o, slv_wdata_o, slv_be_o} = mem[rd_ptr];
    // a response with nothing in flight (and no grant this cycle) has no owner
    assign spurious  = slv_r_valid_i && out_cnt == '0 && !pop;
    assign accept    = slv_r_valid_i && !spurious;

    assign mst_r_valid_o = r_valid_q;
    assign mst_r_rdata_o = r_rdata_q;
    assign mst_r_opc_o   = r_opc_q;
    assign outstanding_o = out_cnt;
    assign err_o         = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ReqDepth; i++) mem[i] <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            out_cnt   <= '0;
            r_valid_q <= 1'b0;
            r_rdata_q <= '0;
            r_opc_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {mst_add_i, mst_wen_i, mst_wdata_i, mst_be_i};
                wr_ptr      <= wr_ptr == LastPtr ? '0 : wr_ptr + PtrW'(1);
            end
            if (pop) rd_ptr <= rd_ptr == LastPtr ? '0 : rd_ptr + PtrW'(1);
            fifo_cnt  <= fifo_cnt + FcW'(push) - FcW'(pop);
            out_cnt   <= out_cnt + CntW'(pop) - CntW'(accept);
            r_valid_q <= accept;
            if (accept) begin
                r_rdata_q <= slv_r_rdata_i;
                r_opc_q   <= slv_r_opc_i;
            end
            if (spurious) err_q <= 1'b1;
        end
    end
endmodule
